// File: rtl/ifetch_stage_pkg.sv
// ifetch_stage_pkg: opcode constants, SEXT format encodings and fetch defaults
package ifetch_stage_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        EXT_I = 3'b000,
        EXT_S = 3'b001,
        EXT_B = 3'b010,
        EXT_U = 3'b011,
        EXT_J = 3'b100
    } ext_op_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Targets are word addresses; low bits of a misaligned target are simply dropped.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/ifetch_sext_sel.sv
// ifetch_sext_sel: maps an RV32I opcode to the immediate format used by SEXT
module ifetch_sext_sel
    import ifetch_stage_pkg::*;
(
    input  logic [6:0] opcode_i,
    output ext_op_e    sext_op_o
);

    // Unknown opcodes fall back to the I format.
    always_comb begin
        sext_op_o = (opcode_i == OP_STORE)                          ? EXT_S :
                    (opcode_i == OP_BRANCH)                         ? EXT_B :
                    (opcode_i == OP_LUI || opcode_i == OP_AUIPC)    ? EXT_U :
                    (opcode_i == OP_JAL)                            ? EXT_J : EXT_I;
    end

endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: PC, synchronous IROM addressing and IF/ID register for the RV32I core
module ifetch_stage
    import ifetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IROM_AW  = 14
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic [IROM_AW-1:0] irom_addr_o,
    input  logic [31:0]        irom_inst_i,
    output logic               id_valid_o,
    output logic [31:0]        id_pc_o,
    output logic [31:0]        id_pc4_o,
    output logic [31:0]        id_inst_o,
    output logic [24:0]        sext_din_o,
    output logic [2:0]         sext_op_o
);

    logic [31:0] pc_q, pc_d;
    logic        f_valid_q, f_valid_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_inst_q, id_inst_d;
    ext_op_e     sext_op;

    // Next PC and IF/ID inputs; redirect flushes and beats stall, stall holds everything.
    always_comb begin
        pc_d       = cpu_rst                  ? RESET_PC :
                     redirect_i               ? align_word(redirect_pc_i) :
                     (stall_i || !f_valid_q)  ? pc_q : pc_q + 32'd4;
        f_valid_d  = 1'b1;
        id_valid_d = redirect_i ? 1'b0 : stall_i ? id_valid_q : f_valid_q;
        id_pc_d    = (redirect_i || stall_i) ? id_pc_q : pc_q;
        id_pc4_d   = (redirect_i || stall_i) ? id_pc4_q : pc_q + 32'd4;
        id_inst_d  = redirect_i ? NOP_INST : stall_i ? id_inst_q : f_valid_q ? irom_inst_i : NOP_INST;
    end

    // The IROM latches pc_d on the same edge, so its data always belongs to pc_q.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            pc_q       <= RESET_PC;
            f_valid_q  <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'd0;
            id_pc4_q   <= 32'd4;
            id_inst_q  <= NOP_INST;
        end else begin
            pc_q       <= pc_d;
            f_valid_q  <= f_valid_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_inst_q  <= id_inst_d;
        end
    end

    ifetch_sext_sel u_sext_sel (
        .opcode_i  (id_inst_q[6:0]),
        .sext_op_o (sext_op)
    );

    assign irom_addr_o = pc_d[IROM_AW+1:2];
    assign id_valid_o  = id_valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_pc4_o    = id_pc4_q;
    assign id_inst_o   = id_inst_q;
    assign sext_din_o  = id_inst_q[31:7];
    assign sext_op_o   = sext_op;

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: random and directed checks of ifetch_stage against an instruction-stream model
module tb_ifetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic [13:0] irom_addr;
    logic [31:0] irom_inst;
    logic        id_valid;
    logic [31:0] id_pc, id_pc4, id_inst;
    logic [24:0] sext_din;
    logic [2:0]  sext_op;

    int checks = 0;
    int failures = 0;

    // Model: the next address to be delivered to decode, and whether IROM data is still cold.
    logic [31:0] m_next = RESET_PC;
    logic        m_cold = 1'b1;
    logic        m_valid = 1'b0;
    logic        m_pck = 1'b0;
    logic [31:0] m_pc = 32'd0, m_pc4 = 32'd4, m_inst = NOP;

    always #5 clk = ~clk;

    ifetch_stage #(.RESET_PC(RESET_PC), .IROM_AW(14)) dut (
        .cpu_clk       (clk),
        .cpu_rst       (cpu_rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .irom_addr_o   (irom_addr),
        .irom_inst_i   (irom_inst),
        .id_valid_o    (id_valid),
        .id_pc_o       (id_pc),
        .id_pc4_o      (id_pc4),
        .id_inst_o     (id_inst),
        .sext_din_o    (sext_din),
        .sext_op_o     (sext_op)
    );

    function automatic logic [31:0] mem_word(input logic [13:0] i);
        case (i)
            14'd100: return 32'h0000_0463;
            14'd101: return 32'h0000_006F;
            14'd102: return 32'h0000_0037;
            14'd103: return 32'h0000_0017;
            14'd104: return 32'h0000_2023;
            14'd105: return 32'h0000_0003;
            14'd106: return 32'h0000_0067;
            14'd107: return 32'h0000_0033;
            default: return 32'h1000_0000 + {18'd0, i};
        endcase
    endfunction

    function automatic logic [2:0] exp_op(input logic [6:0] o);
        case (o)
            7'h13, 7'h03, 7'h67: return 3'b000;
            7'h23:               return 3'b001;
            7'h63:               return 3'b010;
            7'h37, 7'h17:        return 3'b011;
            7'h6F:               return 3'b100;
            default:             return 3'b000;
        endcase
    endfunction

    always @(posedge clk) irom_inst <= mem_word(irom_addr);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        logic [31:0] ea;
        cpu_rst = r;
        stall_i = s;
        redirect_i = d;
        redirect_pc_i = t;
        #1;
        ea = r ? RESET_PC : d ? (t & ~32'h3) : (s || m_cold) ? m_next : m_next + 32'd4;
        check("irom_addr", {18'd0, irom_addr}, {18'd0, ea[15:2]});
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_pc = 32'd0; m_pc4 = 32'd4; m_inst = NOP; m_pck = 1'b1;
            m_next = RESET_PC; m_cold = 1'b1;
        end else begin
            if (d) begin
                m_valid = 1'b0; m_inst = NOP; m_pck = 1'b0; m_next = t & ~32'h3;
            end else if (!s) begin
                if (m_cold) begin
                    m_valid = 1'b0; m_inst = NOP; m_pck = 1'b0;
                end else begin
                    m_valid = 1'b1; m_pc = m_next; m_pc4 = m_next + 32'd4;
                    m_inst = mem_word(m_next[15:2]); m_pck = 1'b1; m_next = m_next + 32'd4;
                end
            end
            m_cold = 1'b0;
        end
        #1;
        check("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
        check("id_inst", id_inst, m_inst);
        check("sext_din", {7'd0, sext_din}, {7'd0, m_inst[31:7]});
        check("sext_op", {29'd0, sext_op}, {29'd0, exp_op(m_inst[6:0])});
        if (m_pck) begin
            check("id_pc", id_pc, m_pc);
            check("id_pc4", id_pc4, m_pc4);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0042);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0190);
        repeat (9) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0080);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 600));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, tgt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
